// File: rtl/tsp_run_ctrl.sv
// Run sequencer for the tsp solver: loads city coordinates, pulses the solver reset,
// then tracks the best tour length until stall, timeout or abort.
module tsp_run_ctrl #(
  parameter int N_CITY      = 64,
  parameter int ADDR_W      = 6,
  parameter int PERF_W      = 32,
  parameter int RST_CYCLES  = 4,
  parameter int STALL_LIMIT = 1048576,
  parameter int MAX_CYCLES  = 268435456
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [7:0]        load_x,
  input  logic [7:0]        load_y,
  output logic              coord_we,
  output logic [ADDR_W-1:0] coord_addr,
  output logic [7:0]        coord_x,
  output logic [7:0]        coord_y,
  output logic              solver_rst,
  input  logic [PERF_W-1:0] performance,
  output logic [PERF_W-1:0] best_perf,
  output logic [15:0]       improve_cnt,
  output logic              busy,
  output logic              done,
  output logic [1:0]        done_reason,
  output logic [2:0]        state
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam int CYC_W   = $clog2(MAX_CYCLES + 1);
  localparam int CLR_W   = $clog2(RST_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);
  localparam logic [CYC_W-1:0]   CYC_LAST   = CYC_W'(MAX_CYCLES - 1);
  localparam logic [CLR_W-1:0]   CLR_LAST   = CLR_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(N_CITY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             st, st_nxt;
  logic [1:0]         reason_nxt;
  logic [ADDR_W-1:0]  addr_cnt;
  logic [CLR_W-1:0]   clr_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic [CYC_W-1:0]   cyc_cnt;
  logic               accept;
  logic               improve;
  logic               restart;

  assign state      = st;
  assign load_ready = (st == S_LOAD);
  assign accept     = load_valid & load_ready;
  assign improve    = (st == S_RUN) && (performance != '0) && (performance < best_perf);
  assign restart    = ((st == S_IDLE) || (st == S_DONE)) && start;

  always_comb begin
    st_nxt     = st;
    reason_nxt = done_reason;
    case (st)
      S_IDLE: if (start) begin
        st_nxt     = S_LOAD;
        reason_nxt = 2'd0;
      end
      S_LOAD: begin
        if (abort)                               st_nxt = S_IDLE;
        else if (accept && addr_cnt == ADDR_LAST) st_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        if (abort) begin
          st_nxt     = S_DONE;
          reason_nxt = 2'd3;
        end else if (clr_cnt == CLR_LAST) begin
          st_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // exit priority: abort, then timeout, then stall
        if (abort) begin
          st_nxt     = S_DONE;
          reason_nxt = 2'd3;
        end else if (cyc_cnt == CYC_LAST) begin
          st_nxt     = S_DONE;
          reason_nxt = 2'd2;
        end else if (!improve && stall_cnt == STALL_LAST) begin
          st_nxt     = S_DONE;
          reason_nxt = 2'd1;
        end
      end
      S_DONE: if (start) begin
        st_nxt     = S_LOAD;
        reason_nxt = 2'd0;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st          <= S_IDLE;
      solver_rst  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_reason <= 2'd0;
    end else begin
      st          <= st_nxt;
      solver_rst  <= (st_nxt == S_IDLE) || (st_nxt == S_LOAD) || (st_nxt == S_CLEAR);
      busy        <= (st_nxt == S_LOAD) || (st_nxt == S_CLEAR) || (st_nxt == S_RUN);
      done        <= (st_nxt == S_DONE);
      done_reason <= reason_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      coord_we    <= 1'b0;
      coord_addr  <= '0;
      coord_x     <= '0;
      coord_y     <= '0;
      addr_cnt    <= '0;
      clr_cnt     <= '0;
      stall_cnt   <= '0;
      cyc_cnt     <= '0;
      best_perf   <= '1;
      improve_cnt <= '0;
    end else begin
      coord_we <= accept;
      if (accept) begin
        coord_addr <= addr_cnt;
        coord_x    <= load_x;
        coord_y    <= load_y;
        addr_cnt   <= addr_cnt + 1'b1;
      end
      if (restart) begin
        addr_cnt    <= '0;
        improve_cnt <= '0;
      end
      clr_cnt <= (st == S_CLEAR) ? clr_cnt + 1'b1 : '0;
      if (st == S_CLEAR && st_nxt == S_RUN) begin
        best_perf <= '1;
        stall_cnt <= '0;
        cyc_cnt   <= '0;
      end
      if (st == S_RUN) begin
        cyc_cnt <= cyc_cnt + 1'b1;
        if (improve) begin
          best_perf <= performance;
          stall_cnt <= '0;
          if (improve_cnt != 16'hFFFF) improve_cnt <= improve_cnt + 16'd1;
        end else begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tsp_run_ctrl.sv
// Bench for tsp_run_ctrl: table-driven reset/load vectors, directed run scenarios,
// then randomized traffic compared against a per-cycle reference model.
module tb_tsp_run_ctrl;

  localparam int N     = 4;
  localparam int RSTC  = 2;
  localparam int STALL = 8;
  localparam int MAXC  = 64;

  logic        clk, rst, start, abort, load_valid, load_ready;
  logic [7:0]  load_x, load_y, coord_x, coord_y;
  logic        coord_we, solver_rst, busy, done;
  logic [1:0]  coord_addr, done_reason;
  logic [31:0] performance, best_perf;
  logic [15:0] improve_cnt;
  logic [2:0]  state;

  tsp_run_ctrl #(
    .N_CITY(N), .ADDR_W(2), .PERF_W(32), .RST_CYCLES(RSTC),
    .STALL_LIMIT(STALL), .MAX_CYCLES(MAXC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_x(load_x), .load_y(load_y),
    .coord_we(coord_we), .coord_addr(coord_addr), .coord_x(coord_x), .coord_y(coord_y),
    .solver_rst(solver_rst), .performance(performance), .best_perf(best_perf),
    .improve_cnt(improve_cnt), .busy(busy), .done(done),
    .done_reason(done_reason), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit rnd_cmp = 0;

  // reference model state, expressed in the externally visible terms
  int          m_st = 0, m_words = 0, m_clr = 0, m_run = 0, m_since = 0;
  int          m_imp = 0, m_reason = 0, m_addr = 0;
  bit          m_we = 0;
  logic [7:0]  m_x = 0, m_y = 0;
  logic [31:0] m_best = 32'hFFFFFFFF;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst) begin
      m_st = 0; m_best = 32'hFFFFFFFF; m_imp = 0; m_reason = 0;
      m_we = 0; m_addr = 0; m_x = 0; m_y = 0; m_words = 0;
      return;
    end
    m_we = 0;
    case (m_st)
      0, 4: if (start) begin m_st = 1; m_words = 0; m_imp = 0; m_reason = 0; end
      1: begin
        if (load_valid) begin
          m_we = 1; m_addr = m_words; m_x = load_x; m_y = load_y; m_words++;
        end
        if (abort) m_st = 0;
        else if (m_words == N) begin m_st = 2; m_clr = RSTC; end
      end
      2: if (abort) begin
        m_st = 4; m_reason = 3;
      end else begin
        m_clr--;
        if (m_clr == 0) begin m_st = 3; m_best = 32'hFFFFFFFF; m_run = 0; m_since = 0; end
      end
      3: begin
        m_run++;
        if (performance != 0 && performance < m_best) begin
          m_best = performance; m_since = 0;
          if (m_imp < 65535) m_imp++;
        end else begin
          m_since++;
        end
        if (abort)                begin m_st = 4; m_reason = 3; end
        else if (m_run == MAXC)   begin m_st = 4; m_reason = 2; end
        else if (m_since == STALL) begin m_st = 4; m_reason = 1; end
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic chk_model();
    chk("m_state", state, m_st);
    chk("m_load_ready", load_ready, m_st == 1);
    chk("m_solver_rst", solver_rst, m_st < 3);
    chk("m_busy", busy, m_st >= 1 && m_st <= 3);
    chk("m_done", done, m_st == 4);
    chk("m_coord_we", coord_we, m_we);
    chk("m_coord_addr", coord_addr, m_addr);
    chk("m_coord_x", coord_x, m_x);
    chk("m_coord_y", coord_y, m_y);
    chk("m_best_perf", best_perf, m_best);
    chk("m_improve_cnt", improve_cnt, m_imp);
    chk("m_done_reason", done_reason, m_reason);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    if (rnd_cmp) chk_model();
  endtask

  task automatic load_words(int n, int base);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1; load_x = 8'(base + i); load_y = 8'(base + 2 * i);
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic start_full_load();
    start = 1'b1; tick(); start = 1'b0;
    load_words(N, 20);
    repeat (RSTC) tick();
  endtask

  typedef struct {
    logic       rstn, st_in, ab, lv;
    logic [7:0] lx, ly;
    logic [2:0] e_state;
    logic       e_srst, e_lr, e_we;
    logic [1:0] e_addr;
    logic [7:0] e_x, e_y;
  } vec_t;

  vec_t tbl[11];

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; load_valid = 1'b0;
    load_x = '0; load_y = '0; performance = '0;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0};
    tbl[1]  = tbl[0];
    tbl[2]  = tbl[0];
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 3'd1, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 8'd2, 3'd1, 1'b1, 1'b1, 1'b1, 2'd0, 8'd1, 8'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 8'd4, 3'd1, 1'b1, 1'b1, 1'b1, 2'd1, 8'd3, 8'd4};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd9, 8'd9, 3'd1, 1'b1, 1'b1, 1'b0, 2'd1, 8'd3, 8'd4};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd5, 8'd6, 3'd1, 1'b1, 1'b1, 1'b1, 2'd2, 8'd5, 8'd6};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'd7, 8'd8, 3'd2, 1'b1, 1'b0, 1'b1, 2'd3, 8'd7, 8'd8};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 3'd2, 1'b1, 1'b0, 1'b0, 2'd3, 8'd7, 8'd8};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 3'd3, 1'b0, 1'b0, 1'b0, 2'd3, 8'd7, 8'd8};

    // reset hold, start, gapped load, clear window
    for (int i = 0; i < 11; i++) begin
      rst = tbl[i].rstn; start = tbl[i].st_in; abort = tbl[i].ab;
      load_valid = tbl[i].lv; load_x = tbl[i].lx; load_y = tbl[i].ly;
      tick();
      chk($sformatf("v%0d_state", i), state, tbl[i].e_state);
      chk($sformatf("v%0d_solver_rst", i), solver_rst, tbl[i].e_srst);
      chk($sformatf("v%0d_load_ready", i), load_ready, tbl[i].e_lr);
      chk($sformatf("v%0d_coord_we", i), coord_we, tbl[i].e_we);
      chk($sformatf("v%0d_coord_addr", i), coord_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_coord_xy", i), {coord_x, coord_y}, {tbl[i].e_x, tbl[i].e_y});
      chk($sformatf("v%0d_best", i), best_perf, 32'hFFFFFFFF);
      chk($sformatf("v%0d_done", i), done, 1'b0);
    end
    start = 1'b0;

    // improvement then stall
    performance = 0;   tick(); chk("s_best_inv", best_perf, 32'hFFFFFFFF);
    performance = 500; tick(); chk("s_best500", best_perf, 500); chk("s_imp1", improve_cnt, 1);
    performance = 400; tick(); chk("s_best400", best_perf, 400); chk("s_imp2", improve_cnt, 2);
    tick();
    performance = 450; tick();
    performance = 400; repeat (5) tick();
    chk("s_still_run", state, 3);
    tick();
    chk("s_state_done", state, 4); chk("s_done", done, 1); chk("s_reason", done_reason, 1);
    chk("s_best_final", best_perf, 400); chk("s_imp_final", improve_cnt, 2);
    chk("s_solver_rst", solver_rst, 0); chk("s_busy", busy, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("done_abort_ign_state", state, 4); chk("done_abort_ign_reason", done_reason, 1);

    // restart from DONE, then timeout
    start = 1'b1; tick(); start = 1'b0;
    chk("rs_state", state, 1); chk("rs_reason", done_reason, 0);
    chk("rs_imp", improve_cnt, 0); chk("rs_busy", busy, 1);
    load_words(N, 10);
    repeat (RSTC) tick();
    chk("to_run", state, 3);
    for (int i = 0; i < MAXC; i++) begin
      performance = 32'(1000 - i);
      tick();
      if (i == MAXC - 2) chk("to_early", state, 3);
    end
    chk("to_state", state, 4); chk("to_reason", done_reason, 2);
    chk("to_best", best_perf, 937); chk("to_imp", improve_cnt, 64);

    // abort coinciding with the stall limit
    start_full_load();
    performance = 0;
    repeat (STALL - 1) tick();
    chk("ab_still_run", state, 3);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_reason", done_reason, 3); chk("ab_state", state, 4);

    // abort in LOAD after 2 words, third word written in the abort cycle
    start = 1'b1; tick(); start = 1'b0;
    load_words(2, 40);
    abort = 1'b1; load_valid = 1'b1; load_x = 8'd77; load_y = 8'd88; tick();
    abort = 1'b0; load_valid = 1'b0;
    chk("la_state", state, 0); chk("la_solver_rst", solver_rst, 1);
    chk("la_we", coord_we, 1); chk("la_addr", coord_addr, 2); chk("la_x", coord_x, 77);
    tick();
    chk("la_no_clear", state, 0); chk("la_we_off", coord_we, 0);

    // abort in CLEAR
    start = 1'b1; tick(); start = 1'b0;
    load_words(N, 50);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ca_state", state, 4); chk("ca_reason", done_reason, 3);

    // reset during RUN
    start_full_load();
    performance = 100; repeat (3) tick();
    chk("rr_best", best_perf, 100);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("rr_state", state, 0); chk("rr_solver_rst", solver_rst, 1);
    chk("rr_best_reset", best_perf, 32'hFFFFFFFF); chk("rr_imp", improve_cnt, 0);

    // randomized traffic against the model
    rnd_cmp = 1;
    begin
      int pdec = 5000;
      bit mode = 0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 99) == 0) mode = ~mode;
        rst        = ($urandom_range(0, 299) != 0);
        start      = ($urandom_range(0, 7) == 0);
        abort      = ($urandom_range(0, 99) == 0);
        load_valid = $urandom_range(0, 1) == 1;
        load_x     = 8'($urandom);
        load_y     = 8'($urandom);
        if (mode) performance = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 6000));
        else      performance = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 6000)) : 32'(pdec);
        pdec = (pdec <= 100) ? 5000 : pdec - 1;
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tsp_run_ctrl.md
Name: tsp_run_ctrl

Overview:
Run sequencer for the `tsp` solver core. It accepts a stream of N_CITY city coordinates and writes them into the solver's coordinate registers. It then holds the solver in reset for a fixed clear window, releases it, and watches its `performance` output. It tracks the best tour length and stops the run on stall, timeout or abort. The block sits between the board-level wrapper (switches, LEDs, 7-seg) and the `tsp` instance.

Parameters:
N_CITY, 64, number of cities; coordinate words accepted per load; power of two, >=2
ADDR_W, 6, coordinate address width; equals log2(N_CITY)
PERF_W, 32, width of performance / best_perf
RST_CYCLES, 4, cycles solver_rst is held high in CLEAR; >=1
STALL_LIMIT, 1048576, consecutive RUN cycles without improvement that end the run
MAX_CYCLES, 268435456, absolute RUN-cycle budget

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge)
start  in  1  begin load; sampled in IDLE and DONE only
abort  in  1  cancel; see Behaviour
load_valid  in  1  coordinate word valid
load_ready  out  1  coordinate word accepted when load_valid&load_ready
load_x  in  8  city x
load_y  in  8  city y
coord_we  out  1  write strobe to solver coordinate regs
coord_addr  out  ADDR_W  city index written
coord_x  out  8  x written
coord_y  out  8  y written
solver_rst  out  1  active-high reset to tsp
performance  in  PERF_W  current tour length from tsp; 0 means invalid
best_perf  out  PERF_W  minimum valid performance seen this run
improve_cnt  out  16  number of improvements this run, saturating at 0xFFFF
busy  out  1  state is LOAD, CLEAR or RUN
done  out  1  state is DONE
done_reason  out  2  0 none, 1 stall, 2 timeout, 3 abort
state  out  3  IDLE=0, LOAD=1, CLEAR=2, RUN=3, DONE=4 (debug/LED)

Behaviour:
- Reset (rst==0 at edge): state=IDLE; solver_rst=1; load_ready=0; coord_we=0.
  - coord_addr, coord_x, coord_y, improve_cnt, done_reason, all counters = 0.
  - best_perf = all ones.
  - Reset mid-operation aborts the run immediately; no final write is issued.
- All outputs are registered. Exception: load_ready, which is a decode of state.
- IDLE: solver_rst=1.
  - start=1 -> LOAD; addr counter=0; improve_cnt=0; done_reason=0.
- LOAD: load_ready=1; solver_rst=1.
  - Each accepted word gives coord_we=1, coord_addr=index, coord_x/y=data on the next cycle (1-cycle latency). Otherwise coord_we=0.
  - Accepting word N_CITY-1 -> CLEAR.
  - abort=1 -> IDLE. A word accepted in the same cycle is still written.
  - Partial loads never start the solver.
- CLEAR: solver_rst=1 for exactly RST_CYCLES cycles, then RUN.
  - On entry to RUN: best_perf=all ones; stall and cycle counters = 0.
  - abort in CLEAR -> DONE, reason 3.
- RUN: solver_rst=0. Each cycle:
  - If performance!=0 and performance<best_perf: best_perf<=performance; stall<=0; improve_cnt++ (saturating).
  - Otherwise stall++. performance==0 never updates best_perf but does count as a non-improvement.
  - Cycle counter increments every cycle.
- RUN exit conditions, evaluated on the same edge with priority abort > timeout > stall:
  - abort=1 -> reason 3.
  - cycle counter == MAX_CYCLES-1 -> reason 2.
  - stall == STALL_LIMIT-1 with no improvement this cycle -> reason 1.
  - Each goes to DONE. An improvement in the exit cycle is still recorded in best_perf.
- DONE: done=1; solver_rst stays 0 so the final path stays displayable.
  - best_perf, improve_cnt and done_reason are frozen.
  - start=1 -> LOAD (full reload); done_reason cleared on that transition.
  - abort in DONE is ignored.
- Counter widths: stall and cycle counters are wide enough for STALL_LIMIT-1 and MAX_CYCLES-1; they never wrap within a run.
- start while busy is ignored. start and abort both high in IDLE -> LOAD (abort ignored in IDLE).

Test Plan:
All scenarios use N_CITY=4, ADDR_W=2, RST_CYCLES=2, STALL_LIMIT=8, MAX_CYCLES=64 unless stated.
1. Reset hold: rst=0 for 3 cycles with start=1 -> state=0, solver_rst=1, best_perf=0xFFFFFFFF, done=0. Release, pulse start -> state=1, load_ready=1.
2. Load with gaps: words (1,2),(3,4),(5,6),(7,8), with load_valid low between words 2 and 3 -> coord_we pulses 4 times at addr 0..3 with matching x/y, each one cycle after acceptance. solver_rst then stays high exactly 2 cycles; state=3 on the following cycle.
3. Improvement/stall: performance sequence 0,500,400,400,450 then constant 400 -> best_perf 500 then 400; improve_cnt=2. DONE with reason 1 exactly 8 cycles after the last improvement (the 400 cycle).
4. Timeout: performance decreasing by 1 every cycle from 1000 -> DONE reason 2 after 64 RUN cycles; best_perf=937; improve_cnt=64.
5. Simultaneous events: abort asserted on the cycle the stall limit hits -> reason 3. Abort during LOAD after 2 words -> IDLE, solver_rst=1, no CLEAR.
6. Restart/reset mid-run: start in DONE -> LOAD, done_reason=0, improve_cnt=0. rst=0 during RUN -> IDLE next edge, solver_rst=1, best_perf=0xFFFFFFFF.
